// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: holds HI/LO and models mult/div latency
// with a busy flag that the decode-stage hazard unit stalls on.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cancel_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] out_o
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

  logic [63:0]     prod_s, prod_u;
  logic [31:0]     abs_a, abs_b, div_b, quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;

  // Signed division is done on magnitudes so 0x80000000 / -1 wraps cleanly.
  always_comb begin
    prod_s  = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    prod_u  = {32'd0, a_i} * {32'd0, b_i};
    div_b   = (b_i == 32'd0) ? 32'd1 : b_i;
    abs_a   = a_i[31] ? (32'd0 - a_i) : a_i;
    abs_b   = div_b[31] ? (32'd0 - div_b) : div_b;
    quo_mag = abs_a / abs_b;
    rem_mag = abs_a % abs_b;
    quo_s   = (a_i[31] ^ div_b[31]) ? (32'd0 - quo_mag) : quo_mag;
    rem_s   = a_i[31] ? (32'd0 - rem_mag) : rem_mag;
    quo_u   = a_i / div_b;
    rem_u   = a_i % div_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    case (state_q)
      IDLE: begin
        if (!cancel_i) begin
          if (start_i && (mdu_op_i >= OP_MULT) && (mdu_op_i <= OP_DIVU)) begin
            state_d = RUN;
            case (mdu_op_i)
              OP_MULT: begin
                {hi_tmp_d, lo_tmp_d} = prod_s;
                cnt_d = CW'(MULT_CYCLES);
              end
              OP_MULTU: begin
                {hi_tmp_d, lo_tmp_d} = prod_u;
                cnt_d = CW'(MULT_CYCLES);
              end
              OP_DIV: begin
                // Divide by zero still runs the full period but commits old HI/LO.
                {hi_tmp_d, lo_tmp_d} = (b_i == 32'd0) ? {hi_q, lo_q} : {rem_s, quo_s};
                cnt_d = CW'(DIV_CYCLES);
              end
              default: begin
                {hi_tmp_d, lo_tmp_d} = (b_i == 32'd0) ? {hi_q, lo_q} : {rem_u, quo_u};
                cnt_d = CW'(DIV_CYCLES);
              end
            endcase
          end else if (mdu_op_i == OP_MTHI) begin
            hi_d = a_i;
          end else if (mdu_op_i == OP_MTLO) begin
            lo_d = a_i;
          end
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          hi_d    = hi_tmp_q;
          lo_d    = lo_tmp_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == RUN);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  always_comb begin
    case (mdu_op_i)
      OP_MFHI: out_o = hi_q;
      OP_MFLO: out_o = lo_q;
      default: out_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed vector table, hand-written corner
// sequences, and randomized ops checked against an arithmetic reference model.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mdu_op_i;
  logic        start_i;
  logic [31:0] a_i, b_i;
  logic        cancel_i;
  logic        busy_o;
  logic [31:0] hi_o, lo_o, out_o;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_hi, m_lo;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .mdu_op_i(mdu_op_i), .start_i(start_i),
    .a_i(a_i), .b_i(b_i), .cancel_i(cancel_i), .busy_o(busy_o),
    .hi_o(hi_o), .lo_o(lo_o), .out_o(out_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural operation.
  task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin p = 64'(a) * 64'(b); m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = 32'(q); m_hi = 32'(r); end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic idle_inputs();
    mdu_op_i = 4'd0; start_i = 1'b0; cancel_i = 1'b0; a_i = '0; b_i = '0;
  endtask

  // Issue one start pulse and count how many sampled cycles busy stays high.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nbusy);
    @(negedge clk);
    mdu_op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(negedge clk);
    idle_inputs();
    nbusy = 0;
    while (busy_o === 1'b1 && nbusy < 100) begin
      nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    mdu_op_i = op; a_i = a;
    @(negedge clk);
    idle_inputs();
  endtask

  vec_t vecs[5];
  int nb;

  initial begin
    vecs[0] = '{4'd1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFE};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{4'd4, 32'd7,        32'd2,        32'd1,        32'd3};
    vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_hi", hi_o, 32'd0);
    chk("reset_lo", lo_o, 32'd0);
    chk("reset_out", out_o, 32'd0);

    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, nb);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(nb), (vecs[i].op <= 4'd2) ? MC : DC);
      chk($sformatf("vec%0d_hi", i), hi_o, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), lo_o, vecs[i].lo);
      m_hi = vecs[i].hi; m_lo = vecs[i].lo;
      if (i == 0) begin
        mdu_op_i = 4'd6; #1;
        chk("mflo_after_mult", out_o, 32'hFFFFFFEB);
        mdu_op_i = 4'd5; #1;
        chk("mfhi_after_mult", out_o, 32'hFFFFFFFF);
        mdu_op_i = 4'd12; #1;
        chk("out_op12", out_o, 32'd0);
        mdu_op_i = 4'd0;
      end
    end

    // MTHI then divide by zero: full busy period, HI/LO untouched.
    do_mt(4'd7, 32'h12345678);
    m_hi = 32'h12345678;
    chk("mthi_hi", hi_o, 32'h12345678);
    do_op(4'd3, 32'd99, 32'd0, nb);
    chk("div0_busy_cycles", 32'(nb), DC);
    chk("div0_hi", hi_o, 32'h12345678);
    chk("div0_lo", lo_o, m_lo);

    // Start suppressed by cancel.
    @(negedge clk);
    mdu_op_i = 4'd1; a_i = 32'd3; b_i = 32'd4; start_i = 1'b1; cancel_i = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("cancel_busy", {31'd0, busy_o}, 32'd0);
    repeat (MC + 1) @(negedge clk);
    chk("cancel_hi", hi_o, m_hi);
    chk("cancel_lo", lo_o, m_lo);

    // MTLO during RUN is ignored; completion value lands.
    @(negedge clk);
    mdu_op_i = 4'd1; a_i = 32'd3; b_i = 32'd4; start_i = 1'b1;
    @(negedge clk);
    idle_inputs();
    mdu_op_i = 4'd8; a_i = 32'hDEADBEEF;
    @(negedge clk);
    idle_inputs();
    chk("mtlo_in_run_lo", lo_o, m_lo);
    nb = 0;
    while (busy_o === 1'b1 && nb < 100) begin nb++; @(negedge clk); end
    chk("mtlo_in_run_done", {31'd0, busy_o}, 32'd0);
    chk("mtlo_in_run_final_lo", lo_o, 32'd12);
    chk("mtlo_in_run_final_hi", hi_o, 32'd0);
    m_hi = 32'd0; m_lo = 32'd12;

    // Reset mid-run discards the pending result.
    @(negedge clk);
    mdu_op_i = 4'd4; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_run_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_run_hi", hi_o, 32'd0);
    chk("rst_run_lo", lo_o, 32'd0);
    repeat (DC + 2) @(negedge clk);
    chk("rst_run_no_late_lo", lo_o, 32'd0);
    chk("rst_run_no_late_busy", {31'd0, busy_o}, 32'd0);
    m_hi = '0; m_lo = '0;

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] ra, rb;
      op = 4'($urandom_range(1, 6));
      if (op >= 4'd5) op = op + 4'd2;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (($urandom_range(0, 3) == 0) && op >= 4'd3 && op <= 4'd4) ra = 32'h80000000;
      if (op >= 4'd7) begin
        do_mt(op, ra);
      end else begin
        do_op(op, ra, rb, nb);
        chk($sformatf("rnd%0d_busy_cycles", i), 32'(nb), (op <= 4'd2) ? MC : DC);
      end
      ref_op(op, ra, rb);
      chk($sformatf("rnd%0d_hi", i), hi_o, m_hi);
      chk($sformatf("rnd%0d_lo", i), lo_o, m_lo);
      mdu_op_i = 4'd5; #1;
      chk($sformatf("rnd%0d_mfhi", i), out_o, m_hi);
      mdu_op_i = 4'd0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit of the five-stage MIPS pipeline. It consumes the forwarded register operands that originate from the GRF read ports, holds the architectural HI/LO registers, and models multi-cycle mult/div latency with a busy flag. The busy flag and the start pulse feed the D-stage hazard unit, which stalls any following HI/LO-touching instruction. mfhi/mflo results return through the E→M pipeline register and ultimately reach the GRF write port.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu, ≥1
- DIV_CYCLES, 10, busy duration for div/divu, ≥1

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- mdu_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9–15 treated as NONE
- start  in  1  one-cycle pulse, qualifies ops 1–4
- a  in  32  rs operand (forwarded)
- b  in  32  rt operand (forwarded)
- cancel  in  1  exception/interrupt in M stage; suppresses this cycle's start/MTHI/MTLO
- busy  out  1  registered; operation in flight
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- out  out  32  combinational read: hi for MFHI, lo for MFLO, else 0

## Operation
- States: IDLE (busy=0) and RUN (busy=1, down-counter cnt).
- IDLE, start=1, op∈1–4, cancel=0: compute result into hi_tmp/lo_tmp; load cnt=MULT_CYCLES or DIV_CYCLES; enter RUN.
- RUN: cnt decrements each edge. At the edge where cnt==1: hi←hi_tmp, lo←lo_tmp, busy←0, return to IDLE.
- MULT: signed 32×32→64; hi=[63:32], lo=[31:0]. MULTU: unsigned.
- DIV: lo=quotient truncated toward zero; hi=remainder with sign of dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- Division by zero (b==0): full busy period is run, and HI/LO are left unchanged at completion.
- MTHI/MTLO in IDLE, cancel=0: hi or lo←a at the edge.
- MTHI/MTLO in RUN: ignored. start in RUN: ignored. Neither must occur, because the hazard unit stalls on busy|start.
- cancel=1: no state change that cycle. cancel does not abort an op already in RUN.
- start with op∉1–4: ignored.
- out reads the current hi/lo registers. It does not bypass a same-cycle MTHI/MTLO.

## Timing
- Reset values: busy=0, hi=0, lo=0, cnt=0, hi_tmp=lo_tmp=0, out=0 (op NONE).
- Start sampled at edge k. busy=1 after edge k through edge k+N−1. At edge k+N, HI/LO are updated and busy=0.
- A mfhi issued at the first cycle where busy=0 reads the new value.
- MTHI/MTLO: the value is visible on hi/lo one cycle after the edge.
- Reset asserted mid-RUN: at that edge, everything returns to reset values and pending results are discarded.
- Reset has priority over start and cancel.
- out is purely combinational from mdu_op/hi/lo, with zero latency.

## Test plan
- Reset, then a=7, b=−3 (0xFFFFFFFD), MULT start → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB; out with MFLO = 0xFFFFFFEB.
- MULTU a=0xFFFFFFFF, b=2 → after 5 cycles hi=1, lo=0xFFFFFFFE.
- DIV a=−7, b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1. DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- MTHI a=0x12345678, then DIV by 0 → busy 10 cycles, hi stays 0x12345678.
- DIV start, reset at cycle 4 → busy=0, hi=lo=0 next cycle; no later update.
- MULT start with cancel=1 → busy stays 0, hi/lo unchanged. MTLO during RUN → lo unchanged until completion value.
